lut_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one registered 32-entry multiple-of-constant ROM (5-bit address, 49-bit data, one-cycle read latency) among NUM_REQ independent requesters in the modular-reduction datapath. Each requester issues one address with a valid/ready handshake and receives the ROM word in a private response register with its own valid/ready handshake. One ROM read is issued per cycle at most. Each requester has at most one transaction outstanding.

---
 rtl/lut_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_lut_rr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lut_rr_arbiter.sv
// Round-robin arbiter sharing one registered multiple-of-constant ROM among NUM_REQ requesters.
// Optional statistics counters are enabled by defining LUT_ARB_STATS_EN.
module lut_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 5,
  parameter int DW      = 49
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*DW-1:0] rsp_data,
  output logic [AW-1:0]         lut_addr,
  input  logic [DW-1:0]         lut_dout,
  output logic                  busy
`ifdef LUT_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grants,
  output logic [31:0]           stat_stalls
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  logic [PW-1:0]      ptr_reg;
  logic [PW-1:0]      ptr_next;
  logic [PW-1:0]      pipe_tag_reg;
  logic [PW-1:0]      grant_idx;
  logic               pipe_vld_reg;
  logic               grant_any;
  logic [NUM_REQ-1:0] inflight_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [NUM_REQ-1:0] eligible;
  logic [DW-1:0]      rsp_data_reg [NUM_REQ];
  logic [AW-1:0]      addr_arr [NUM_REQ];
  logic [PW:0]        cand;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign addr_arr[gi]            = req_addr[gi*AW +: AW];
      assign rsp_data[gi*DW +: DW]   = rsp_data_reg[gi];
      // A response being consumed this cycle frees the slot for the next word.
      assign eligible[gi] = req_valid[gi] & ~inflight_reg[gi]
                          & (~rsp_valid_reg[gi] | rsp_ready[gi]);
    end
  endgenerate

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (!grant_any && eligible[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    lut_addr  = '0;
    ptr_next  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      lut_addr             = addr_arr[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      pipe_vld_reg  <= 1'b0;
      pipe_tag_reg  <= '0;
      inflight_reg  <= '0;
      rsp_valid_reg <= '0;
      for (int k = 0; k < NUM_REQ; k++) rsp_data_reg[k] <= '0;
    end else begin
      pipe_vld_reg <= grant_any;
      if (grant_any) begin
        pipe_tag_reg <= grant_idx;
        ptr_reg      <= ptr_next;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        // ROM return has priority over the consume of the previous word.
        if (pipe_vld_reg && pipe_tag_reg == PW'(k)) begin
          rsp_valid_reg[k] <= 1'b1;
          rsp_data_reg[k]  <= lut_dout;
          inflight_reg[k]  <= 1'b0;
        end else if (rsp_valid_reg[k] && rsp_ready[k]) begin
          rsp_valid_reg[k] <= 1'b0;
        end
        if (grant_any && grant_idx == PW'(k)) inflight_reg[k] <= 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign busy      = pipe_vld_reg | (|inflight_reg) | (|rsp_valid_reg);

`ifdef LUT_ARB_STATS_EN
  logic [31:0] stat_grants_reg;
  logic [31:0] stat_stalls_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants_reg <= '0;
      stat_stalls_reg <= '0;
    end else begin
      if (grant_any) stat_grants_reg <= stat_grants_reg + 32'd1;
      if ((|req_valid) && !grant_any && stat_stalls_reg != '1)
        stat_stalls_reg <= stat_stalls_reg + 32'd1;
    end
  end

  assign stat_grants = stat_grants_reg;
  assign stat_stalls = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_lut_rr_arbiter.sv
// Directed bench for lut_rr_arbiter: ROM model, expected grants per step, response scoreboard.
// Stats counters are checked when LUT_ARB_STATS_EN is defined.
module tb_lut_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 49;
  localparam logic [DW-1:0] K = 49'd13125370249215;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*DW-1:0] rsp_data;
  logic [AW-1:0]   lut_addr;
  logic [DW-1:0]   lut_dout;
  logic            busy;
`ifdef LUT_ARB_STATS_EN
  logic [31:0]     stat_grants;
  logic [31:0]     stat_stalls;
`endif

  lut_rr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .lut_addr(lut_addr), .lut_dout(lut_dout), .busy(busy)
`ifdef LUT_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Registered ROM: word = address * constant, one cycle after the address.
  always @(posedge clk) lut_dout <= DW'(lut_addr) * K;

  logic [AW-1:0] addr [N];
  assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ent_t;
  ent_t sb [N][$];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int n_grants   = 0;
  int n_stalls   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    addr[0] = a0; addr[1] = a1; addr[2] = a2; addr[3] = a3;
  endtask

  // One clock cycle: drive, check at negedge, update scoreboard, advance.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] rr, input logic [N-1:0] g);
    logic          bexp;
    logic          ev;
    logic [AW-1:0] la;
    ent_t          e;
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    bexp = 1'b0;
    for (int i = 0; i < N; i++)
      if (sb[i].size() > 0 && sb[i][0].due <= cyc + 1) bexp = 1'b1;
    chk("busy", 64'(busy), 64'(bexp));
    chk("req_ready", 64'(req_ready), 64'(g));
    la = '0;
    for (int i = 0; i < N; i++) if (g[i]) la = addr[i];
    chk("lut_addr", 64'(lut_addr), 64'(la));
    for (int i = 0; i < N; i++) begin
      ev = (sb[i].size() > 0) && (sb[i][0].due <= cyc);
      chk($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(ev));
      if (ev) begin
        chk($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i*DW +: DW]), 64'(sb[i][0].data));
        if (rr[i]) void'(sb[i].pop_front());
      end
    end
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        e.due  = cyc + 2;
        e.data = DW'(addr[i]) * K;
        sb[i].push_back(e);
        n_grants++;
      end
    end
    if ((|v) && g == '0) n_stalls++;
    $display("cycle %0d valid=%b rsp_ready=%b grant=%b rsp_valid=%b busy=%b",
             cyc, v, rr, req_ready, rsp_valid, busy);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_pulse();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) sb[i].delete();
    n_grants = 0;
    n_stalls = 0;
    @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst lut_addr", 64'(lut_addr), 64'd0);
    for (int i = 0; i < N; i++)
      chk($sformatf("rst rsp_data[%0d]", i), 64'(rsp_data[i*DW +: DW]), 64'd0);
    $display("reset applied at cycle %0d", cyc);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    set_addrs(5'd0, 5'd0, 5'd0, 5'd0);
    reset_pulse();

    // Single read: addr 1 from requester 0, busy falls at T+3.
    set_addrs(5'd1, 5'd0, 5'd0, 5'd0);
    step(4'b0001, 4'b1111, 4'b0001);
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b1111, 4'b0000);

    // Grant requester 1 (ptr moves to 2), then reset the following cycle.
    set_addrs(5'd0, 5'd7, 5'd0, 5'd0);
    step(4'b0010, 4'b1111, 4'b0010);
    reset_pulse();
    for (int k = 0; k < 2; k++) step(4'b0000, 4'b1111, 4'b0000);

    // All four request together: ptr back at 0 gives 0,1,2,3.
    set_addrs(5'd2, 5'd8, 5'd16, 5'd31);
    step(4'b1111, 4'b1111, 4'b0001);
    step(4'b1110, 4'b1111, 4'b0010);
    step(4'b1100, 4'b1111, 4'b0100);
    step(4'b1000, 4'b1111, 4'b1000);
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b1111, 4'b0000);

    // Back-pressure on requester 1 while others keep being granted.
    set_addrs(5'd6, 5'd3, 5'd10, 5'd20);
    step(4'b0010, 4'b1101, 4'b0010);
    addr[1] = 5'd4;
    step(4'b1111, 4'b1101, 4'b0100);
    step(4'b1111, 4'b1101, 4'b1000);
    step(4'b1111, 4'b1101, 4'b0001);
    step(4'b1111, 4'b1101, 4'b0100);
    step(4'b1111, 4'b1101, 4'b1000);
    step(4'b0010, 4'b1101, 4'b0000);
    step(4'b0010, 4'b1111, 4'b0010);
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b1111, 4'b0000);

    // Fairness: ptr is 2, requesters 0 and 3 valid -> 3 then 0.
    set_addrs(5'd9, 5'd0, 5'd0, 5'd12);
    step(4'b1001, 4'b1111, 4'b1000);
    step(4'b0001, 4'b1111, 4'b0001);
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b1111, 4'b0000);

`ifdef LUT_ARB_STATS_EN
    chk("stat_grants", 64'(stat_grants), 64'(n_grants));
    chk("stat_stalls", 64'(stat_stalls), 64'(n_stalls));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
